raiz_bus_master: RTL and testbench

- Hardware bus initiator for the square-root peripheral. It replaces software driving the cs/rd/wr/addr bus.
- On `start` it runs the fixed command sequence:
  1. write operand to OP_A (0x04);
  2. write INIT=1 (0x08);
  3. poll DONE (0x10) until bit0=1 or timeout;
  4. read RESULT (0x0C);
  5. write INIT=0 to re-arm the peripheral.
- Sits between a local controller (keypad/display FSM) and the peripheral's bus port.

---
 rtl/raiz_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_raiz_bus_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raiz_bus_master.sv
// Bus initiator for the square-root peripheral: writes the operand, starts it,
// polls DONE with a bounded retry count, reads the result and re-arms the peripheral.
module raiz_bus_master #(
  parameter logic [4:0]  ADDR_OPA  = 5'h04,
  parameter logic [4:0]  ADDR_INIT = 5'h08,
  parameter logic [4:0]  ADDR_RES  = 5'h0C,
  parameter logic [4:0]  ADDR_DONE = 5'h10,
  parameter int unsigned POLL_MAX  = 200,
  parameter int unsigned POLL_GAP  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_operand,
  output logic [15:0] o_result,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout_err,
  output logic        o_bus_cs,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [4:0]  o_bus_addr,
  output logic [15:0] o_bus_dout,
  input  logic [15:0] i_bus_din
);

  localparam logic [7:0] PollMax = 8'(POLL_MAX);
  localparam logic [3:0] GapLast = 4'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    StIdle, StWrA, StWrInit, StPoll, StChk, StGap, StRdRes, StClrInit, StFinish, StTimeout
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_phase, w_phase_d;
  logic [15:0] r_op, w_op_d;
  logic [7:0]  r_poll_cnt;
  logic [3:0]  r_gap_cnt;
  logic        r_done_bit;
  logic [15:0] r_result;
  logic        r_terr;
  logic        r_cs, r_rd, r_wr, r_busy, r_done;
  logic [4:0]  r_addr;
  logic [15:0] r_dout;
  logic        w_cs, w_rd, w_wr, w_busy, w_done;
  logic [4:0]  w_addr;
  logic [15:0] w_dout;
  logic        w_accept;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_op_d   = w_accept ? i_operand : r_op;

  // Bus states take two cycles: phase 0 carries the strobe, phase 1 is the turnaround.
  always_comb begin
    w_state_d = r_state;
    w_phase_d = 1'b0;
    case (r_state)
      StIdle:    if (i_start) w_state_d = StWrA;
      StWrA:     if (!r_phase) w_phase_d = 1'b1; else w_state_d = StWrInit;
      StWrInit:  if (!r_phase) w_phase_d = 1'b1; else w_state_d = StPoll;
      StPoll:    if (!r_phase) w_phase_d = 1'b1; else w_state_d = StChk;
      StChk: begin
        if (r_done_bit)                w_state_d = StRdRes;
        else if (r_poll_cnt == PollMax) w_state_d = StTimeout;
        else if (POLL_GAP == 0)        w_state_d = StPoll;
        else                           w_state_d = StGap;
      end
      StGap:     if (r_gap_cnt == GapLast) w_state_d = StPoll;
      StRdRes:   if (!r_phase) w_phase_d = 1'b1; else w_state_d = StClrInit;
      StClrInit: if (!r_phase) w_phase_d = 1'b1; else w_state_d = StFinish;
      StFinish:  w_state_d = StIdle;
      StTimeout: if (!r_phase) w_phase_d = 1'b1; else w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every bus pin comes straight from a flop.
  always_comb begin
    w_cs   = 1'b0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = 5'h00;
    w_dout = 16'h0000;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (w_state_d)
      StIdle: w_busy = 1'b0;
      StWrA: begin
        w_addr = ADDR_OPA;
        if (!w_phase_d) begin
          w_cs   = 1'b1;
          w_wr   = 1'b1;
          w_dout = w_op_d;
        end
      end
      StWrInit: begin
        w_addr = ADDR_INIT;
        if (!w_phase_d) begin
          w_cs   = 1'b1;
          w_wr   = 1'b1;
          w_dout = 16'h0001;
        end
      end
      StPoll: begin
        w_addr = ADDR_DONE;
        if (!w_phase_d) begin
          w_cs = 1'b1;
          w_rd = 1'b1;
        end
      end
      StRdRes: begin
        w_addr = ADDR_RES;
        if (!w_phase_d) begin
          w_cs = 1'b1;
          w_rd = 1'b1;
        end
      end
      StClrInit, StTimeout: begin
        w_addr = ADDR_INIT;
        if (!w_phase_d) begin
          w_cs = 1'b1;
          w_wr = 1'b1;
        end else if (w_state_d == StTimeout) begin
          w_busy = 1'b0;
        end
      end
      StFinish: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_phase    <= 1'b0;
      r_op       <= 16'h0000;
      r_poll_cnt <= 8'h00;
      r_gap_cnt  <= 4'h0;
      r_done_bit <= 1'b0;
      r_result   <= 16'h0000;
      r_terr     <= 1'b0;
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= 5'h00;
      r_dout     <= 16'h0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_op    <= w_op_d;
      r_cs    <= w_cs;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_addr  <= w_addr;
      r_dout  <= w_dout;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_accept) r_poll_cnt <= 8'h00;
      else if (r_state == StPoll && r_phase) r_poll_cnt <= r_poll_cnt + 8'd1;
      r_gap_cnt <= (r_state == StGap) ? r_gap_cnt + 4'd1 : 4'd0;
      // Read data is sampled at the edge closing the turnaround cycle.
      if (r_state == StPoll && r_phase) r_done_bit <= i_bus_din[0];
      if (r_state == StRdRes && r_phase) r_result <= i_bus_din;
      if (w_accept) r_terr <= 1'b0;
      else if (w_state_d == StTimeout) r_terr <= 1'b1;
    end
  end

  assign o_result      = r_result;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_terr;
  assign o_bus_cs      = r_cs;
  assign o_bus_rd      = r_rd;
  assign o_bus_wr      = r_wr;
  assign o_bus_addr    = r_addr;
  assign o_bus_dout    = r_dout;

endmodule

// File: tb/tb_raiz_bus_master.sv
// Bench for raiz_bus_master: behavioural square-root peripheral, bus trace monitor,
// table-driven and randomized transactions plus hand-written corner sequences.
module tb_raiz_bus_master;

  logic        clk, rst_n, start;
  logic [15:0] operand, result, bus_dout, bus_din;
  logic        busy, done, terr, bus_cs, bus_rd, bus_wr;
  logic [4:0]  bus_addr;

  raiz_bus_master dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_operand(operand),
    .o_result(result), .o_busy(busy), .o_done(done), .o_timeout_err(terr),
    .o_bus_cs(bus_cs), .o_bus_rd(bus_rd), .o_bus_wr(bus_wr), .o_bus_addr(bus_addr),
    .o_bus_dout(bus_dout), .i_bus_din(bus_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [15:0] isqrt(input logic [15:0] x);
    for (int r = 255; r >= 0; r--) if (r * r <= int'(x)) return 16'(r);
    return 16'h0;
  endfunction

  // Peripheral model: DONE rises p_delay cycles after INIT=1 (never if p_never).
  int          p_delay = 20;
  bit          p_never = 1'b0;
  logic [15:0] p_junk = 16'hA5A4;
  logic [15:0] p_opa = 16'h0, p_init = 16'h0;
  logic        p_done = 1'b0;
  int          p_cnt = 0;

  always @(posedge clk) begin
    if (bus_cs && bus_wr) begin
      if (bus_addr == 5'h04) p_opa <= bus_dout;
      if (bus_addr == 5'h08) begin
        p_init <= bus_dout;
        if (bus_dout[0]) begin
          p_done <= (p_delay == 0) && !p_never;
          p_cnt  <= p_never ? 0 : p_delay;
        end else begin
          p_done <= 1'b0;
          p_cnt  <= 0;
        end
      end
    end else if (p_cnt != 0) begin
      p_cnt <= p_cnt - 1;
      if (p_cnt == 1) p_done <= 1'b1;
    end
  end

  always_comb begin
    bus_din = 16'hDEAD;
    case (bus_addr)
      5'h04:   bus_din = p_opa;
      5'h08:   bus_din = p_init;
      5'h0C:   bus_din = isqrt(p_opa);
      5'h10:   bus_din = {p_junk[15:1], p_done};
      default: bus_din = 16'hDEAD;
    endcase
  end

  // Monitor: trace entry = {wr, rd, addr, write data}.
  logic [22:0] trace[$];
  logic [15:0] done_res_q[$];
  int          done_cyc_q[$];
  int          cyc = 0, rise_cyc = 0, mon_polls = 0, excl_bad = 0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_busy <= busy;
    if (busy && !prev_busy) rise_cyc <= cyc;
    if (done) begin
      done_res_q.push_back(result);
      done_cyc_q.push_back(cyc);
    end
    if (bus_cs || bus_rd || bus_wr) begin
      trace.push_back({bus_wr, bus_rd, bus_addr, bus_wr ? bus_dout : 16'h0});
      if (bus_rd && bus_addr == 5'h10) mon_polls <= mon_polls + 1;
      if (!bus_cs || (bus_rd == bus_wr)) excl_bad <= excl_bad + 1;
    end
  end

  function automatic logic [22:0] tw(input logic [4:0] a, input logic [15:0] d);
    return {2'b10, a, d};
  endfunction

  function automatic logic [22:0] tr(input logic [4:0] a);
    return {2'b01, a, 16'h0};
  endfunction

  function automatic int count_entry(input logic [22:0] e);
    int n = 0;
    foreach (trace[i]) if (trace[i] == e) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    trace.delete();
    done_res_q.delete();
    done_cyc_q.delete();
    mon_polls = 0;
    excl_bad  = 0;
  endtask

  task automatic kick(input logic [15:0] op);
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    @(negedge clk);
    start   = 1'b0;
    operand = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_idle_in_time"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] op;
    int          delay;
    bit          never;
    logic [15:0] exp_res;
  } vec_t;

  task automatic run_vec(input string name, input vec_t v);
    int n, n_poll;
    p_delay = v.delay;
    p_never = v.never;
    clear_mon();
    kick(v.op);
    chk({name, "_terr_cleared"}, 64'(terr), 64'd0);
    wait_idle(name);
    n = trace.size();
    n_poll = count_entry(tr(5'h10));
    chk({name, "_result"}, 64'(result), 64'(v.exp_res));
    chk({name, "_done_pulses"}, 64'(done_res_q.size()), v.never ? 64'd0 : 64'd1);
    chk({name, "_timeout_err"}, 64'(terr), 64'(v.never));
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    chk({name, "_strobe_excl"}, 64'(excl_bad), 64'd0);
    chk({name, "_trace_len"}, 64'(n >= 4), 64'd1);
    if (n >= 4) begin
      chk({name, "_wr_opa"}, 64'(trace[0]), 64'(tw(5'h04, v.op)));
      chk({name, "_wr_init1"}, 64'(trace[1]), 64'(tw(5'h08, 16'h1)));
      chk({name, "_wr_init0"}, 64'(trace[n-1]), 64'(tw(5'h08, 16'h0)));
      chk({name, "_poll_span"}, 64'(n_poll), 64'(n - (v.never ? 3 : 4)));
      if (v.never) chk({name, "_poll_count"}, 64'(n_poll), 64'd200);
      else chk({name, "_rd_res"}, 64'(trace[n-2]), 64'(tr(5'h0C)));
    end
    if (!v.never && done_res_q.size() == 1) begin
      chk({name, "_result_at_done"}, 64'(done_res_q[0]), 64'(v.exp_res));
      if (v.delay == 0) begin
        chk({name, "_one_poll"}, 64'(n_poll), 64'd1);
        chk({name, "_latency"}, 64'(done_cyc_q[0] - rise_cyc), 64'd11);
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    int sz;
    bit ok;
    tbl[0] = '{16'd81,    20, 1'b0, 16'd9};
    tbl[1] = '{16'd16,     0, 1'b1, 16'd9};
    tbl[2] = '{16'd0,     20, 1'b0, 16'd0};
    tbl[3] = '{16'd65535, 20, 1'b0, 16'd255};
    tbl[4] = '{16'd2,     20, 1'b0, 16'd1};
    tbl[5] = '{16'd25,     0, 1'b0, 16'd5};

    start = 1'b0;
    operand = 16'h0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #4;
    chk("reset_outputs", {bus_cs, bus_rd, bus_wr, bus_addr, bus_dout, busy, done, terr, result},
        64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.op = 16'($urandom);
      v.delay = int'($urandom_range(0, 25));
      v.never = 1'b0;
      v.exp_res = isqrt(v.op);
      p_junk = 16'($urandom);
      run_vec($sformatf("rand%0d", i), v);
    end
    p_junk = 16'hA5A4;

    // Start while busy is neither queued nor re-latched.
    p_delay = 20;
    p_never = 1'b0;
    clear_mon();
    kick(16'd81);
    for (int c = 0; c < 100 && mon_polls == 0; c++) begin
      @(negedge clk);
      #1;
    end
    kick(16'd16);
    wait_idle("ign");
    chk("ign_result", 64'(result), 64'd9);
    chk("ign_one_opa_write", 64'(count_entry(tw(5'h04, 16'h51))), 64'd1);
    chk("ign_no_opa16", 64'(count_entry(tw(5'h04, 16'd16))), 64'd0);
    chk("ign_done_pulses", 64'(done_res_q.size()), 64'd1);

    // Asynchronous reset while sitting in the inter-poll gap.
    clear_mon();
    kick(16'd81);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (mon_polls != 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rst_poll_seen", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    sz = trace.size();
    rst_n = 1'b0;
    #1;
    chk("rst_async_bus", {bus_cs, bus_rd, bus_wr, bus_addr, bus_dout}, 64'd0);
    chk("rst_async_status", {busy, done, terr, result}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_more_cycles", 64'(trace.size()), 64'(sz));
    run_vec("post_rst", '{16'd144, 20, 1'b0, 16'd12});

    // Back-to-back with start held high.
    p_delay = 0;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    operand = 16'd25;
    for (int c = 0; c < 200 && done_res_q.size() == 0; c++) begin
      @(negedge clk);
      #1;
    end
    operand = 16'd49;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (busy) break;
    end
    start = 1'b0;
    wait_idle("b2b");
    chk("b2b_done_pulses", 64'(done_res_q.size()), 64'd2);
    if (done_res_q.size() == 2) begin
      chk("b2b_res0", 64'(done_res_q[0]), 64'd5);
      chk("b2b_res1", 64'(done_res_q[1]), 64'd7);
      chk("b2b_spacing", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'd13);
    end
    chk("b2b_opa_writes", 64'(count_entry(tw(5'h04, 16'd25)) + count_entry(tw(5'h04, 16'd49))),
        64'd2);
    chk("b2b_strobe_excl", 64'(excl_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
